alu_ctl_pipe: RTL and testbench

Pipelined, extended ALU control unit for the pipelined MIPS core, sitting at the ID/EX boundary. It decodes ALUOp/Funct into a registered ALU operation code for the full MIPS-I integer R-type and I-type arithmetic/logic subset, and flags illegal encodings instead of emitting X. It also sequences a fixed-latency multiply/divide unit with a two-state controller, issuing the start pulse and stalling dependent instructions while the unit is busy.

---
 rtl/alu_ctl_pkg.sv | 66 ++++++
 rtl/alu_ctl_decode.sv | 68 ++++++
 rtl/alu_ctl_pipe.sv | 127 ++++++++++++
 tb/tb_alu_ctl_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctl_pkg.sv
// Shared constants for the pipelined ALU control unit: ALU op codes, R-type
// Funct values, I-type selectors, mul/div op encoding and the mul/div FSM state.
package alu_ctl_pkg;

    // ALUOp field from the main decoder
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpRtype = 2'b10;
    localparam logic [1:0] AluOpItype = 2'b11;

    // ALU operation codes; the 3-bit subset keeps legacy values
    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpNor  = 4'b0100;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSlt  = 4'b0111;
    localparam logic [3:0] OpSll  = 4'b1000;
    localparam logic [3:0] OpSrl  = 4'b1001;
    localparam logic [3:0] OpSra  = 4'b1010;
    localparam logic [3:0] OpLui  = 4'b1011;
    localparam logic [3:0] OpMfhi = 4'b1100;
    localparam logic [3:0] OpMflo = 4'b1101;
    localparam logic [3:0] OpSltu = 4'b1111;

    // R-type Funct values
    localparam logic [5:0] FnSll   = 6'd0;
    localparam logic [5:0] FnSrl   = 6'd2;
    localparam logic [5:0] FnSra   = 6'd3;
    localparam logic [5:0] FnMfhi  = 6'd16;
    localparam logic [5:0] FnMflo  = 6'd18;
    localparam logic [5:0] FnMult  = 6'd24;
    localparam logic [5:0] FnMultu = 6'd25;
    localparam logic [5:0] FnDiv   = 6'd26;
    localparam logic [5:0] FnDivu  = 6'd27;
    localparam logic [5:0] FnAdd   = 6'd32;
    localparam logic [5:0] FnAddu  = 6'd33;
    localparam logic [5:0] FnSub   = 6'd34;
    localparam logic [5:0] FnSubu  = 6'd35;
    localparam logic [5:0] FnAnd   = 6'd36;
    localparam logic [5:0] FnOr    = 6'd37;
    localparam logic [5:0] FnXor   = 6'd38;
    localparam logic [5:0] FnNor   = 6'd39;
    localparam logic [5:0] FnSlt   = 6'd42;
    localparam logic [5:0] FnSltu  = 6'd43;

    // I-type selector (Funct[2:0] carries opcode[2:0])
    localparam logic [2:0] ISelAdd  = 3'b000;
    localparam logic [2:0] ISelAddu = 3'b001;
    localparam logic [2:0] ISelSlt  = 3'b010;
    localparam logic [2:0] ISelSltu = 3'b011;
    localparam logic [2:0] ISelAnd  = 3'b100;
    localparam logic [2:0] ISelOr   = 3'b101;
    localparam logic [2:0] ISelXor  = 3'b110;
    localparam logic [2:0] ISelLui  = 3'b111;

    // mul/div op encoding, equal to Funct[1:0] of Funct 24..27
    localparam logic [1:0] MdMult  = 2'b00;
    localparam logic [1:0] MdMultu = 2'b01;
    localparam logic [1:0] MdDiv   = 2'b10;
    localparam logic [1:0] MdDivu  = 2'b11;

    typedef enum logic [0:0] {StIdle, StBusy} md_state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUOp/Funct decoder. Mul/div and mfhi/mflo decode only when
// ALU_CTL_MULDIV_EN is defined; otherwise those Funct values are illegal.
module alu_ctl_decode (
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] op,
    output logic       illegal,
    output logic       md_class,
    output logic [1:0] md_op,
    output logic       hi_lo_read
);
    import alu_ctl_pkg::*;

    // Decode ALUOp/Funct; unknown R-type encodings fall back to add and flag illegal
    always_comb begin
        op         = OpAdd;
        illegal    = 1'b0;
        md_class   = 1'b0;
        md_op      = funct[1:0];
        hi_lo_read = 1'b0;
        case (alu_op)
            AluOpAdd: op = OpAdd;
            AluOpSub: op = OpSub;
            AluOpItype: begin
                case (funct[2:0])
                    ISelAdd, ISelAddu: op = OpAdd;
                    ISelSlt:           op = OpSlt;
                    ISelSltu:          op = OpSltu;
                    ISelAnd:           op = OpAnd;
                    ISelOr:            op = OpOr;
                    ISelXor:           op = OpXor;
                    default:           op = OpLui;
                endcase
            end
            default: begin
                case (funct)
                    FnSll:           op = OpSll;
                    FnSrl:           op = OpSrl;
                    FnSra:           op = OpSra;
                    FnAdd, FnAddu:   op = OpAdd;
                    FnSub, FnSubu:   op = OpSub;
                    FnAnd:           op = OpAnd;
                    FnOr:            op = OpOr;
                    FnXor:           op = OpXor;
                    FnNor:           op = OpNor;
                    FnSlt:           op = OpSlt;
                    FnSltu:          op = OpSltu;
`ifdef ALU_CTL_MULDIV_EN
                    FnMfhi: begin
                        op         = OpMfhi;
                        hi_lo_read = 1'b1;
                    end
                    FnMflo: begin
                        op         = OpMflo;
                        hi_lo_read = 1'b1;
                    end
                    FnMult, FnMultu, FnDiv, FnDivu: begin
                        op       = OpAdd;
                        md_class = 1'b1;
                    end
`endif
                    default:         illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctl_pipe.sv
// Pipelined ALU control at the ID/EX boundary: registered op/valid/illegal plus a
// fixed-latency mul/div sequencer. Optional feature macro: ALU_CTL_MULDIV_EN.
module alu_ctl_pipe #(
    parameter int unsigned OP_W   = 4,
    parameter int unsigned MD_LAT = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic [1:0]      ALUOp,
    input  logic [5:0]      Funct,
    input  logic            stall_in,
    input  logic            flush,
    output logic            hold,
    output logic [OP_W-1:0] ALUOperation,
    output logic            valid_out,
    output logic            illegal,
    output logic            md_start,
    output logic [1:0]      md_op,
    output logic            md_busy,
    output logic            md_done
);
    import alu_ctl_pkg::*;

    logic [3:0] dec_op;
    logic       dec_illegal;
    logic       dec_md_class;
    logic [1:0] dec_md_op;
    logic       dec_hi_lo_read;
    logic       accept;

    alu_ctl_decode u_decode (
        .alu_op     (ALUOp),
        .funct      (Funct),
        .op         (dec_op),
        .illegal    (dec_illegal),
        .md_class   (dec_md_class),
        .md_op      (dec_md_op),
        .hi_lo_read (dec_hi_lo_read)
    );

    assign accept = valid_in & ~stall_in & ~hold & ~flush;

    // Output register: flush beats stall, stall holds everything, else load or bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ALUOperation <= '0;
            valid_out    <= 1'b0;
            illegal      <= 1'b0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else if (!stall_in) begin
            valid_out <= accept;
            if (accept) begin
                ALUOperation <= OP_W'(dec_op);
                illegal      <= dec_illegal;
            end
        end
    end

`ifdef ALU_CTL_MULDIV_EN
    localparam int unsigned CntW = $clog2(MD_LAT);

    md_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]    md_op_d;
    logic          md_start_d;

    // Stall dependent instructions (another mul/div or a HI/LO read) while busy
    assign hold    = valid_in & md_busy & (dec_md_class | dec_hi_lo_read);
    assign md_busy = (state_q == StBusy);
    assign md_done = md_busy & (cnt_q == '0);

    // Next state: launch on an accepted mul/div, count down to 0 while busy
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_op_d    = md_op;
        md_start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && dec_md_class) begin
                    state_d    = StBusy;
                    cnt_d      = CntW'(MD_LAT - 1);
                    md_op_d    = dec_md_op;
                    md_start_d = 1'b1;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Mul/div state, counter, latched op and start pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            md_op    <= MdMult;
            md_start <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            md_op    <= md_op_d;
            md_start <= md_start_d;
        end
    end
`else
    localparam int unsigned unused_md_lat = MD_LAT;
    logic unused_md;

    // Mul/div support not built: sequencer outputs are tied low
    assign unused_md = ^{dec_md_class, dec_md_op, dec_hi_lo_read};
    assign hold      = 1'b0;
    assign md_start  = 1'b0;
    assign md_op     = 2'b00;
    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctl_pipe.sv
// Self-checking bench for alu_ctl_pipe: decode table through a scoreboard, plus
// stall/flush, mul/div sequencing and asynchronous reset sequences.
module tb_alu_ctl_pipe;
    localparam int unsigned OpW   = 4;
    localparam int unsigned MdLat = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           valid_in;
    logic [1:0]     ALUOp;
    logic [5:0]     Funct;
    logic           stall_in;
    logic           flush;
    logic           hold;
    logic [OpW-1:0] ALUOperation;
    logic           valid_out;
    logic           illegal;
    logic           md_start;
    logic [1:0]     md_op;
    logic           md_busy;
    logic           md_done;

    alu_ctl_pipe #(.OP_W(OpW), .MD_LAT(MdLat)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_in     (valid_in),
        .ALUOp        (ALUOp),
        .Funct        (Funct),
        .stall_in     (stall_in),
        .flush        (flush),
        .hold         (hold),
        .ALUOperation (ALUOperation),
        .valid_out    (valid_out),
        .illegal      (illegal),
        .md_start     (md_start),
        .md_op        (md_op),
        .md_busy      (md_busy),
        .md_done      (md_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] alu_op;
        logic [5:0] funct;
        logic [3:0] op;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [3:0] op;
        logic       ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add_vec(input logic [1:0] a, input logic [5:0] f,
                                    input logic [3:0] o, input logic i);
        vec_t v;
        v.alu_op = a;
        v.funct  = f;
        v.op     = o;
        v.ill    = i;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic v, input logic [1:0] a, input logic [5:0] f);
        valid_in = v;
        ALUOp    = a;
        Funct    = f;
    endtask

    task automatic push_exp(input logic [3:0] o, input logic i);
        exp_t e;
        e.op  = o;
        e.ill = i;
        sb.push_back(e);
    endtask

    // One clock; a fresh (non-stalled, non-flushed) valid_out pops the scoreboard
    task automatic tick();
        logic quiet;
        exp_t e;
        quiet = stall_in | flush;
        @(posedge clk);
        #1;
        if (valid_out && !quiet) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got valid_out op %0h with nothing expected",
                         ALUOperation);
            end else begin
                e = sb.pop_front();
                check("sb_op", 32'(ALUOperation), 32'(e.op));
                check("sb_illegal", 32'(illegal), 32'(e.ill));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_op"}, 32'(ALUOperation), 0);
        check({tag, "_valid"}, 32'(valid_out), 0);
        check({tag, "_illegal"}, 32'(illegal), 0);
        check({tag, "_md_start"}, 32'(md_start), 0);
        check({tag, "_md_op"}, 32'(md_op), 0);
        check({tag, "_md_busy"}, 32'(md_busy), 0);
        check({tag, "_md_done"}, 32'(md_done), 0);
    endtask

    initial begin
        int  busy_n;
        int  hold_n;
        int  done_n;
        int  done_at;
        int  start_n;
        bit  accepted;

        reset_n = 1'b0;
        drive(1'b0, 2'b00, 6'd0);
        stall_in = 1'b0;
        flush    = 1'b0;

        // Decode table: R-type, I-type, fixed add/sub, illegal encodings
        add_vec(2'b10, 6'd42, 4'b0111, 1'b0);
        add_vec(2'b10, 6'd43, 4'b1111, 1'b0);
        add_vec(2'b10, 6'd0,  4'b1000, 1'b0);
        add_vec(2'b10, 6'd2,  4'b1001, 1'b0);
        add_vec(2'b10, 6'd3,  4'b1010, 1'b0);
        add_vec(2'b10, 6'd32, 4'b0010, 1'b0);
        add_vec(2'b10, 6'd33, 4'b0010, 1'b0);
        add_vec(2'b10, 6'd34, 4'b0110, 1'b0);
        add_vec(2'b10, 6'd35, 4'b0110, 1'b0);
        add_vec(2'b10, 6'd36, 4'b0000, 1'b0);
        add_vec(2'b10, 6'd37, 4'b0001, 1'b0);
        add_vec(2'b10, 6'd38, 4'b0011, 1'b0);
        add_vec(2'b10, 6'd39, 4'b0100, 1'b0);
        add_vec(2'b10, 6'd50, 4'b0010, 1'b1);
        add_vec(2'b10, 6'd1,  4'b0010, 1'b1);
        add_vec(2'b11, 6'o70, 4'b0010, 1'b0);
        add_vec(2'b11, 6'o51, 4'b0010, 1'b0);
        add_vec(2'b11, 6'o12, 4'b0111, 1'b0);
        add_vec(2'b11, 6'o63, 4'b1111, 1'b0);
        add_vec(2'b11, 6'o24, 4'b0000, 1'b0);
        add_vec(2'b11, 6'o45, 4'b0001, 1'b0);
        add_vec(2'b11, 6'o06, 4'b0011, 1'b0);
        add_vec(2'b11, 6'o77, 4'b1011, 1'b0);
        add_vec(2'b00, 6'd42, 4'b0010, 1'b0);
        add_vec(2'b01, 6'd36, 4'b0110, 1'b0);
`ifdef ALU_CTL_MULDIV_EN
        add_vec(2'b10, 6'd16, 4'b1100, 1'b0);
        add_vec(2'b10, 6'd18, 4'b1101, 1'b0);
`else
        add_vec(2'b10, 6'd16, 4'b0010, 1'b1);
        add_vec(2'b10, 6'd18, 4'b0010, 1'b1);
        add_vec(2'b10, 6'd24, 4'b0010, 1'b1);
        add_vec(2'b10, 6'd27, 4'b0010, 1'b1);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_hold", 32'(hold), 0);
        reset_n = 1'b1;

        // Table through the scoreboard, one instruction per cycle
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].alu_op, vecs[i].funct);
            push_exp(vecs[i].op, vecs[i].ill);
            tick();
        end
        drive(1'b0, 2'b00, 6'd0);
        tick();
        check("table_bubble_valid", 32'(valid_out), 0);
        check("table_drain", 32'(sb.size()), 0);

        // Stall holds a loaded sub; flush beats stall
        drive(1'b1, 2'b01, 6'd0);
        push_exp(4'b0110, 1'b0);
        tick();
        stall_in = 1'b1;
        drive(1'b1, 2'b00, 6'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_op", 32'(ALUOperation), 32'(4'b0110));
            check("stall_valid", 32'(valid_out), 1);
        end
        flush = 1'b1;
        tick();
        check("flush_stall_valid", 32'(valid_out), 0);
        flush    = 1'b0;
        stall_in = 1'b0;
        drive(1'b0, 2'b00, 6'd0);
        tick();
        check("stall_drain", 32'(sb.size()), 0);

`ifdef ALU_CTL_MULDIV_EN
        // mult then a dependent mfhi held for the whole operation
        drive(1'b1, 2'b10, 6'd24);
        push_exp(4'b0010, 1'b0);
        tick();
        check("mult_start", 32'(md_start), 1);
        check("mult_op", 32'(md_op), 0);
        drive(1'b1, 2'b10, 6'd16);
        push_exp(4'b1100, 1'b0);
        busy_n = 0; hold_n = 0; done_n = 0; done_at = 0; start_n = 0; accepted = 1'b0;
        for (int c = 1; c <= 3 * int'(MdLat) && !accepted; c++) begin
            #1;
            if (md_busy)  busy_n++;
            if (hold)     hold_n++;
            if (md_start) start_n++;
            if (md_done) begin
                done_n++;
                done_at = c;
            end
            if (!hold) accepted = 1'b1;
            tick();
        end
        drive(1'b0, 2'b00, 6'd0);
        check("mfhi_accepted", 32'(accepted), 1);
        check("mult_busy_cycles", 32'(busy_n), MdLat);
        check("mfhi_hold_cycles", 32'(hold_n), MdLat);
        check("mult_start_pulses", 32'(start_n), 1);
        check("mult_done_pulses", 32'(done_n), 1);
        check("mult_done_cycle", 32'(done_at), MdLat);
        check("mfhi_op", 32'(ALUOperation), 32'(4'b1100));
        check("mfhi_drain", 32'(sb.size()), 0);

        // div interrupted by reset at busy cycle 3, then a clean restart
        drive(1'b1, 2'b10, 6'd26);
        push_exp(4'b0010, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'd0);
        check("div_op", 32'(md_op), 32'(2'b10));
        tick();
        tick();
        check("div_busy_c3", 32'(md_busy), 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("div_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b1, 2'b10, 6'd26);
        push_exp(4'b0010, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'd0);
        check("div2_start", 32'(md_start), 1);
        check("div2_op", 32'(md_op), 32'(2'b10));
        busy_n = md_busy ? 1 : 0;
        for (int c = 0; c < 3 * int'(MdLat) && md_busy; c++) begin
            tick();
            if (md_busy) busy_n++;
        end
        check("div2_busy_cycles", 32'(busy_n), MdLat);
        check("div2_drain", 32'(sb.size()), 0);
`else
        // Mul/div disabled: mult is illegal and never starts anything
        drive(1'b1, 2'b10, 6'd24);
        push_exp(4'b0010, 1'b1);
        #1;
        check("nomd_hold", 32'(hold), 0);
        tick();
        drive(1'b0, 2'b00, 6'd0);
        check("nomd_illegal", 32'(illegal), 1);
        check("nomd_start", 32'(md_start), 0);
        check("nomd_busy", 32'(md_busy), 0);

        // Mid-operation asynchronous reset
        drive(1'b1, 2'b01, 6'd0);
        push_exp(4'b0110, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'd0);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b1, 2'b10, 6'd42);
        push_exp(4'b0111, 1'b0);
        tick();
        drive(1'b0, 2'b00, 6'd0);
        check("post_reset_valid", 32'(valid_out), 1);
        check("nomd_drain", 32'(sb.size()), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
